// File: rtl/fifo_pkg.sv
// Shared types and helpers for the width-converting FIFO: flush FSM
// encodings, the lane-keep mask and the explicit-wrap pointer adder.
package fifo_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } flush_state_e;

   localparam int unsigned MASK_W = 32;

   function automatic logic [MASK_W-1:0] keep_mask(input int unsigned n, input int unsigned par);
      logic [MASK_W-1:0] m;
      m = {MASK_W{1'b0}};
      for (int unsigned i = 0; i < MASK_W; i++) begin
         m[i] = (i < n) && (i < par);
      end
      return m;
   endfunction

   // ptr < size and n <= size always hold, so one conditional subtract wraps it
   function automatic int unsigned ptr_add(input int unsigned ptr, input int unsigned n,
                                           input int unsigned size);
      int unsigned s;
      s = ptr + n;
      if (s >= size) begin
         s = s - size;
      end
      return s;
   endfunction

endpackage

// File: rtl/fifo_gearbox_mem.sv
// Word storage for the gearbox FIFO: PAR_WRITE write lanes and PAR_READ
// combinational read lanes, each addressed with explicit modulo-MEM_SIZE wrap.
module fifo_gearbox_mem
   import fifo_pkg::*;
#(
   parameter int SIZE      = 16,
   parameter int MEM_SIZE  = 8,
   parameter int PAR_WRITE = 2,
   parameter int PAR_READ  = 4,
   parameter int PTR_W     = 3
) (
   input  logic                      clk_i,
   input  logic                      we_i,
   input  logic [PTR_W-1:0]          wr_ptr_i,
   input  logic [SIZE*PAR_WRITE-1:0] din_i,
   input  logic [PTR_W-1:0]          rd_ptr_i,
   output logic [SIZE*PAR_READ-1:0]  rd_data_o
);

   logic [SIZE-1:0] mem_q [MEM_SIZE];

   // Contents are deliberately not reset; level and pointers define validity
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < PAR_WRITE; i++) begin
            mem_q[PTR_W'(ptr_add(32'(wr_ptr_i), i, MEM_SIZE))] <= din_i[i*SIZE +: SIZE];
         end
      end
   end

   always_comb begin
      rd_data_o = {(SIZE*PAR_READ){1'b0}};
      for (int i = 0; i < PAR_READ; i++) begin
         rd_data_o[i*SIZE +: SIZE] = mem_q[PTR_W'(ptr_add(32'(rd_ptr_i), i, MEM_SIZE))];
      end
   end

endmodule

// File: rtl/fifo_gearbox.sv
// Width-converting FIFO: PAR_WRITE words in, PAR_READ words out, with level,
// almost flags and a flush mode that drains a partial remainder under out_keep.
module fifo_gearbox
   import fifo_pkg::*;
#(
   parameter int SIZE      = 16,
   parameter int MEM_SIZE  = 8,
   parameter int PAR_WRITE = 2,
   parameter int PAR_READ  = 4,
   parameter int AF_LEVEL  = MEM_SIZE - PAR_WRITE,
   parameter int AE_LEVEL  = PAR_READ,
   parameter int LVL_W     = $clog2(MEM_SIZE + 1)
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      clear,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SIZE*PAR_WRITE-1:0] din,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SIZE*PAR_READ-1:0]  dout,
   output logic [PAR_READ-1:0]       out_keep,
   input  logic                      flush,
   output logic [LVL_W-1:0]          level,
   output logic                      almost_full,
   output logic                      almost_empty
);

   localparam int PTR_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam logic [LVL_W-1:0] LVL_ROOM = LVL_W'(MEM_SIZE - PAR_WRITE);
   localparam logic [LVL_W-1:0] LVL_PR   = LVL_W'(PAR_READ);
   localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_LEVEL);
   localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_LEVEL);
   localparam logic [LVL_W:0]   PW_X     = (LVL_W+1)'(PAR_WRITE);

   flush_state_e                state_q, state_d;
   logic [LVL_W-1:0]            level_q, level_d;
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]            kept_s;
   logic [LVL_W:0]              level_ext_s;
   logic                        ir_s, ov_s, wr_s, rd_s;
   logic [PAR_READ-1:0]         keep_s;
   logic [SIZE*PAR_READ-1:0]    rd_data_s;
   logic [SIZE*PAR_READ-1:0]    dout_s;

   fifo_gearbox_mem #(
      .SIZE      (SIZE),
      .MEM_SIZE  (MEM_SIZE),
      .PAR_WRITE (PAR_WRITE),
      .PAR_READ  (PAR_READ),
      .PTR_W     (PTR_W)
   ) u_mem (
      .clk_i     (clk),
      .we_i      (wr_s && rstn && !clear),
      .wr_ptr_i  (wr_ptr_q),
      .din_i     (din),
      .rd_ptr_i  (rd_ptr_q),
      .rd_data_o (rd_data_s)
   );

   // Handshake flags, lane mask and masked read data, all from registered state
   always_comb begin
      kept_s = (level_q >= LVL_PR) ? LVL_PR : level_q;
      ir_s   = (state_q == IDLE) && (level_q <= LVL_ROOM);
      ov_s   = (level_q >= LVL_PR) || ((state_q == DRAIN) && (level_q != {LVL_W{1'b0}}));
      keep_s = ov_s ? PAR_READ'(keep_mask(32'(kept_s), PAR_READ)) : {PAR_READ{1'b0}};
      dout_s = {(SIZE*PAR_READ){1'b0}};
      for (int i = 0; i < PAR_READ; i++) begin
         dout_s[i*SIZE +: SIZE] = keep_s[i] ? rd_data_s[i*SIZE +: SIZE] : {SIZE{1'b0}};
      end
   end

   // Next level, pointers and flush state
   always_comb begin
      wr_s        = in_valid && ir_s;
      rd_s        = ov_s && out_ready;
      level_ext_s = {1'b0, level_q} + (wr_s ? PW_X : {(LVL_W+1){1'b0}})
                    - (rd_s ? {1'b0, kept_s} : {(LVL_W+1){1'b0}});
      level_d     = LVL_W'(level_ext_s);
      wr_ptr_d    = wr_s ? PTR_W'(ptr_add(32'(wr_ptr_q), PAR_WRITE, MEM_SIZE)) : wr_ptr_q;
      rd_ptr_d    = rd_s ? PTR_W'(ptr_add(32'(rd_ptr_q), 32'(kept_s), MEM_SIZE)) : rd_ptr_q;
      state_d     = state_q;
      case (state_q)
         IDLE: begin
            if (flush) state_d = DRAIN;
            else       state_d = IDLE;
         end
         DRAIN: begin
            if (level_d == {LVL_W{1'b0}}) state_d = IDLE;
            else                          state_d = DRAIN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset and clear share one effect; reset outranks clear only nominally
   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         state_q  <= IDLE;
         level_q  <= {LVL_W{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   assign in_ready     = ir_s;
   assign out_valid    = ov_s;
   assign out_keep     = keep_s;
   assign dout         = dout_s;
   assign level        = level_q;
   assign almost_full  = (level_q >= LVL_AF);
   assign almost_empty = (level_q < LVL_AE);

endmodule

// File: doc/fifo_gearbox.md
# fifo_gearbox

Parametrised width-converting FIFO: it accepts PAR_WRITE words per write beat and delivers PAR_READ words per read beat. It uses valid/ready handshakes on both sides. It adds a fill-level output, programmable almost-full/almost-empty flags, and a flush mode that drains a partial remainder with a lane-keep mask. It sits between producer and consumer stages whose parallelism differs, and replaces the fixed wen/ren FIFO in the datapath.

## Interface
- SIZE, 16, bits per word
- MEM_SIZE, 8, storage depth in words; any value ≥ max(PAR_WRITE, PAR_READ), power of two not required
- PAR_WRITE, 2, words accepted per write beat
- PAR_READ, 4, words delivered per read beat
- AF_LEVEL, MEM_SIZE-PAR_WRITE, almost_full asserted when level ≥ AF_LEVEL
- AE_LEVEL, PAR_READ, almost_empty asserted when level < AE_LEVEL
- LVL_W, $clog2(MEM_SIZE+1), level width
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock
- rstn  in  1  synchronous active-low reset
- clear  in  1  synchronous flush-to-empty, discards contents
- in_valid  in  1  write beat offered
- in_ready  out  1  write beat can be accepted
- din  in  SIZE*PAR_WRITE  write words; lane 0 (din[SIZE-1:0]) is oldest
- out_valid  out  1  read beat available
- out_ready  in  1  consumer takes read beat
- dout  out  SIZE*PAR_READ  read words; lane 0 is oldest
- out_keep  out  PAR_READ  per-lane valid mask for dout
- flush  in  1  request drain of partial remainder
- level  out  LVL_W  words stored
- almost_full, almost_empty  out  1  threshold flags

## Operation
- Write is accepted when in_valid && in_ready. All PAR_WRITE lanes are stored at wr_ptr..wr_ptr+PAR_WRITE-1, modulo MEM_SIZE.
- Read is accepted when out_valid && out_ready. rd_ptr advances by the number of kept lanes, modulo MEM_SIZE.
- Pointer wrap is explicit. If ptr+n ≥ MEM_SIZE, the new pointer is ptr+n-MEM_SIZE. No power-of-two masking is used.
- in_ready = !flush_pending && (level ≤ MEM_SIZE-PAR_WRITE). The flag comes from the registered level only; a read in the same cycle does not open space.
- out_valid = (level ≥ PAR_READ) || (flush_pending && level > 0).
- out_keep:
  - all ones for a normal beat;
  - for a flush-remainder beat (level < PAR_READ), the low `level` bits only.
- dout lanes outside out_keep are 0. dout is all 0 whenever out_valid=0.
- level_next = level + (wr ? PAR_WRITE : 0) − (rd ? kept_lanes : 0). Compute it in LVL_W+1 bits. Simultaneous write and read both take effect.
- Flush state machine:
  - States: IDLE and DRAIN; flush_pending=1 in DRAIN.
  - IDLE→DRAIN on flush=1.
  - DRAIN→IDLE when level reaches 0, either by the remainder read being accepted or when level already is 0.
  - While in DRAIN, full beats are read normally before the remainder.
  - flush while already in DRAIN is ignored.
- Priority: rstn=0 > clear > normal operation. clear zeroes pointers, level and flush state, and ignores that cycle's write and read. Memory contents are not reset.
- almost_full and almost_empty are combinational from registered level.

## Timing
- After reset or clear:
  - level=0, in_ready=1, out_valid=0;
  - out_keep=0, dout=0;
  - almost_empty=1, almost_full=0;
  - state IDLE.
- First-word-fall-through: data written at edge N appears on dout with out_valid by the following cycle, once the threshold is met. Latency is 1 cycle.
- All flags update on the edge after the transfer that changes level.
- Reset asserted mid-transfer: the beat is lost, and the state is as after reset on the next cycle.
- A flush request at edge N gives in_ready=0 from cycle N+1.
- in_ready returns on the cycle after level reaches 0.

## Structure
- Shared package (fifo_pkg):
  - lane-mask function keep_mask(n, PAR_READ);
  - modular pointer-add function;
  - flush state encodings IDLE/DRAIN.
- One sub-module, fifo_gearbox_mem:
  - MEM_SIZE×SIZE register array;
  - PAR_WRITE write lanes with wrap addressing;
  - PAR_READ combinational read lanes with wrap addressing.
- Top level holds pointers, level, handshake and flush FSM.

## Test plan
- Reset, then 2 writes of {0x0001,0x0002},{0x0003,0x0004} -> out_valid=1, dout lanes 0..3 = 1,2,3,4, out_keep=4'b1111; read -> level=0, almost_empty=1.
- 4 writes with out_ready=0 -> level=8, in_ready=0, almost_full=1. The 5th in_valid beat is not accepted and data is unchanged.
- level=6, simultaneous write and read -> level=4. Lanes read in order across the pointer wrap (rd_ptr 6→2).
- 1 write {0xA,0xB}, pulse flush -> out_valid=1, dout = {0,0,0xB,0xA}, out_keep=4'b0011, in_ready=0. After the read: level=0, in_ready=1 next cycle.
- Full FIFO, assert clear with in_valid and out_ready high -> next cycle level=0, no transfer counted, out_valid=0.
- Configuration PAR_WRITE=4, PAR_READ=2, MEM_SIZE=12, then 3 writes with random reads -> output stream equals input stream word-for-word, and level never exceeds 12.
